pll_lock_rst_seq: RTL
=====================

Name: pll_lock_rst_seq

Overview:
- Consumes the `locked` status of the clock-wizard PLL and turns it into ordered, glitch-free resets for downstream clock domains.
- Owns the PLL reset: it pulses the reset, waits for lock, then requires lock to stay stable before releasing domain resets one at a time.
- On loss of lock or lock timeout it re-arms the whole sequence.
- Runs on the free-running board clock, upstream of the PLL.

Parameters:
- RST_PULSE_CYC, 16: width of the pll_reset pulse in clk cycles (≥1).
- LOCK_TIMEOUT_CYC, 65536: cycles allowed in WAIT_LOCK before the PLL is reset again.
- LOCK_STABLE_CYC, 1024: consecutive synchronized-lock-high cycles required before any release.
- NUM_DOMAINS, 4: number of domain reset outputs (1..8).
- RELEASE_GAP_CYC, 8: cycles between successive domain releases (≥1).

Ports:
- clk  in  1  free-running board clock, rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- pll_locked  in  1  PLL lock status; asynchronous to clk.
- pll_reset  out  1  active-high reset to the PLL.
- dom_rst_n  out  NUM_DOMAINS  active-low domain resets; bit 0 is released first.
- all_ready  out  1  high once every domain is released.
- fault_cnt  out  8  count of lock losses plus lock timeouts; saturates at 255.
- seq_state  out  3  state code: 0 RESET_PLL, 1 WAIT_LOCK, 2 STABLE, 3 RELEASE, 4 RUN.

Behaviour:
- Synchronizer: pll_locked passes through a 2-FF synchronizer to give lock_s. Only lock_s is used internally. Input-to-lock_s latency is 2 cycles.
- All outputs are registered.
- Reset (sys_rst=1 at an edge): state=RESET_PLL, counters=0, pll_reset=1, dom_rst_n=all 0, all_ready=0, fault_cnt=0. Synchronizer flops clear to 0.
- RESET_PLL:
  - pll_reset=1.
  - Counts RST_PULSE_CYC cycles after sys_rst low, then goes to WAIT_LOCK.
  - pll_reset is therefore high for exactly RST_PULSE_CYC cycles after the first edge with sys_rst low.
- WAIT_LOCK:
  - pll_reset=0; timeout counter starts at 0.
  - lock_s=1 -> STABLE.
  - Counter reaches LOCK_TIMEOUT_CYC-1 with lock_s=0 -> RESET_PLL and fault_cnt+1.
- STABLE:
  - Counts consecutive lock_s=1 cycles.
  - lock_s=0 -> WAIT_LOCK with a fresh timeout count; no PLL reset, no fault.
  - Count reaches LOCK_STABLE_CYC -> RELEASE.
- RELEASE:
  - dom_rst_n[0] rises on the first RELEASE cycle.
  - dom_rst_n[i] rises i*RELEASE_GAP_CYC cycles later.
  - The cycle after dom_rst_n[NUM_DOMAINS-1] rises -> RUN and all_ready=1.
- RUN: holds until lock loss.
- Lock loss in RELEASE or RUN (lock_s=0):
  - Next edge: dom_rst_n=all 0, all_ready=0, pll_reset=1, state=RESET_PLL, fault_cnt+1.
  - Total latency from pll_locked falling to dom_rst_n low is 3 cycles.
- Released bits never re-assert individually; all domains drop together.
- fault_cnt saturates at 255 and is cleared only by sys_rst.
- sys_rst asserted in any state aborts immediately to the reset values on the same edge.
- Glitch on pll_locked shorter than 1 cycle may or may not be captured. If captured, it is handled by the rules above, with no special filtering beyond STABLE.

Test Plan (RST_PULSE_CYC=4, LOCK_TIMEOUT_CYC=32, LOCK_STABLE_CYC=8, NUM_DOMAINS=3, RELEASE_GAP_CYC=2):
1. Normal start: sys_rst high 3 cycles, pll_locked rises 10 cycles after sys_rst falls -> pll_reset high 4 cycles after release; dom_rst_n goes 001, 011, 111 at 2-cycle spacing; all_ready=1 the cycle after; fault_cnt=0.
2. Timeout: pll_locked held 0 -> pll_reset re-pulses 4 cycles every 32+4 cycles; fault_cnt increments once per timeout.
3. Unstable lock: pll_locked high 5 cycles, low 1, then high -> returns to WAIT_LOCK; no release until 8 clean cycles; pll_reset stays 0; fault_cnt unchanged.
4. Loss in RUN: pll_locked drops -> 3 cycles later dom_rst_n=000, all_ready=0, pll_reset=1, fault_cnt=1; sequence then replays as in scenario 1.
5. Loss mid-RELEASE: pll_locked drops after dom_rst_n=001 -> all bits low, fault_cnt+1, no further release.
6. Abort and saturation: sys_rst pulsed during STABLE -> all outputs return to reset values on that edge. Force 260 timeouts -> fault_cnt reads 255.

Source files
------------

// File: rtl/pll_lock_rst_seq_if.sv
// PLL-facing and domain-facing signals of the lock/reset sequencer.
// The master side is the sequencer; the slave side is the PLL plus the reset consumers.
interface pll_lock_rst_seq_if #(
  parameter int NUM_DOMAINS = 4
);
  logic                   pll_locked;
  logic                   pll_reset;
  logic [NUM_DOMAINS-1:0] dom_rst_n;
  logic                   all_ready;
  logic [7:0]             fault_cnt;
  logic [2:0]             seq_state;

  modport master (
    input  pll_locked,
    output pll_reset,
    output dom_rst_n,
    output all_ready,
    output fault_cnt,
    output seq_state
  );

  modport slave (
    output pll_locked,
    input  pll_reset,
    input  dom_rst_n,
    input  all_ready,
    input  fault_cnt,
    input  seq_state
  );
endinterface

// File: rtl/pll_lock_rst_seq.sv
// PLL lock supervisor: pulses the PLL reset, waits for a stable lock, then
// releases the downstream domain resets one by one. Any lock loss or lock
// timeout re-arms the whole sequence and bumps a saturating fault counter.
// Every output is a flop, so domain resets cannot glitch.
module pll_lock_rst_seq #(
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_TIMEOUT_CYC = 65536,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int NUM_DOMAINS      = 4,
  parameter int RELEASE_GAP_CYC  = 8
) (
  input  logic                clk,
  input  logic                sys_rst,
  pll_lock_rst_seq_if.master  bus
);

  localparam logic [2:0] S_RESET_PLL = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_STABLE    = 3'd2;
  localparam logic [2:0] S_RELEASE   = 3'd3;
  localparam logic [2:0] S_RUN       = 3'd4;

  // One shared counter serves every timed state, so it is sized for the longest interval.
  localparam int MAX_A   = (RST_PULSE_CYC > LOCK_TIMEOUT_CYC) ? RST_PULSE_CYC : LOCK_TIMEOUT_CYC;
  localparam int MAX_B   = (LOCK_STABLE_CYC > RELEASE_GAP_CYC) ? LOCK_STABLE_CYC : RELEASE_GAP_CYC;
  localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] RST_LAST     = CW'(RST_PULSE_CYC - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST     = CW'(RELEASE_GAP_CYC - 1);
  localparam logic [7:0]    FAULT_MAX    = 8'hFF;

  logic                   sync1_q;
  logic                   lock_s_q;
  logic [2:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   pll_reset_q, pll_reset_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic                   ready_q, ready_d;
  logic [7:0]             fault_q, fault_d;
  logic [7:0]             fault_inc;

  assign fault_inc = (fault_q == FAULT_MAX) ? fault_q : fault_q + 8'd1;

  // Two-flop synchronizer bringing the asynchronous PLL lock into the board clock domain.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= bus.pll_locked;
      lock_s_q <= sync1_q;
    end
  end

  // Sequencer next-state logic; outputs are computed here so they change on the same edge as the state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pll_reset_d = pll_reset_q;
    dom_d       = dom_q;
    ready_d     = ready_q;
    fault_d     = fault_q;
    case (state_q)
      S_RESET_PLL: begin
        pll_reset_d = 1'b1;
        if (cnt_q == RST_LAST) begin
          state_d     = S_WAIT_LOCK;
          cnt_d       = '0;
          pll_reset_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        if (lock_s_q) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d     = S_RESET_PLL;
          cnt_d       = '0;
          pll_reset_d = 1'b1;
          fault_d     = fault_inc;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STABLE: begin
        if (!lock_s_q) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = S_RELEASE;
          cnt_d   = '0;
          dom_d   = NUM_DOMAINS'(1);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RELEASE: begin
        if (!lock_s_q) begin
          state_d     = S_RESET_PLL;
          cnt_d       = '0;
          pll_reset_d = 1'b1;
          dom_d       = '0;
          ready_d     = 1'b0;
          fault_d     = fault_inc;
        end else if (dom_q[NUM_DOMAINS-1]) begin
          state_d = S_RUN;
          ready_d = 1'b1;
        end else if (cnt_q == GAP_LAST) begin
          dom_d = (dom_q << 1) | NUM_DOMAINS'(1);
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (!lock_s_q) begin
          state_d     = S_RESET_PLL;
          cnt_d       = '0;
          pll_reset_d = 1'b1;
          dom_d       = '0;
          ready_d     = 1'b0;
          fault_d     = fault_inc;
        end
      end
      default: begin
        state_d     = S_RESET_PLL;
        cnt_d       = '0;
        pll_reset_d = 1'b1;
        dom_d       = '0;
        ready_d     = 1'b0;
      end
    endcase
  end

  // Sequencer registers; sys_rst overrides whatever the state machine was doing on the same edge.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q     <= S_RESET_PLL;
      cnt_q       <= '0;
      pll_reset_q <= 1'b1;
      dom_q       <= '0;
      ready_q     <= 1'b0;
      fault_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pll_reset_q <= pll_reset_d;
      dom_q       <= dom_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
    end
  end

  assign bus.pll_reset = pll_reset_q;
  assign bus.dom_rst_n = dom_q;
  assign bus.all_ready = ready_q;
  assign bus.fault_cnt = fault_q;
  assign bus.seq_state = state_q;

endmodule
